decoder_scan_sequencer: RTL and testbench

Upstream driver for the 3-to-8 enable decoder. It steps a 3-bit row select through rows 0..7 and holds the decoder enable high for a programmable dwell per row. An optional blanking gap, with enable low, separates rows. Used for LED-matrix and keypad row scanning, in one-shot or continuous mode, under a start/stop handshake.

---
 rtl/decoder_scan_sequencer_pkg.sv | 21 ++
 rtl/decoder_scan_sequencer_if.sv | 26 ++
 rtl/decoder_scan_sequencer_scan_dwell_timer.sv | 32 +++
 rtl/decoder_scan_sequencer.sv | 133 +++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for row-scan sequencers driving the 3-to-8 enable decoder.
// Imported by the sequencer, its interface and any bench that talks to the decoder.
package decoder_scan_sequencer_pkg;

  localparam int SEL_W    = 3;
  localparam int NUM_ROWS = 8;

  localparam logic [SEL_W-1:0] LAST_ROW = SEL_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    SCAN_IDLE   = 2'd0,
    SCAN_ACTIVE = 2'd1,
    SCAN_BLANK  = 2'd2
  } scan_state_t;

  // Bit width needed to hold a cycle count of up to max_cycles.
  function automatic int count_width(input int max_cycles);
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control and decoder-drive signals of the row-scan sequencer, plus its FSM state for observation.
// start/stop/mode_oneshot are level inputs sampled on each rising clk edge; every other signal is a registered output.
interface decoder_scan_sequencer_if;
  import decoder_scan_sequencer_pkg::*;

  logic             start;
  logic             stop;
  logic             mode_oneshot;
  logic [SEL_W-1:0] select;
  logic             enable;
  logic             row_done;
  logic             frame_done;
  logic             busy;
  scan_state_t      state;

  modport master (
    output start, stop, mode_oneshot,
    input  select, enable, row_done, frame_done, busy, state
  );

  modport slave (
    input  start, stop, mode_oneshot,
    output select, enable, row_done, frame_done, busy, state
  );

endinterface

// File: rtl/decoder_scan_sequencer_scan_dwell_timer.sv
// Loadable down-counter timing both the per-row dwell and the inter-row blanking gap.
// count holds the cycles left in the current phase, so expire marks the phase's final cycle.
module scan_dwell_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire,
  output logic         expire_next
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

  // Look-ahead lets the parent register row_done one cycle before it is shown.
  assign expire_next = load ? (value == W'(1))
                            : ({1'b0, count} == (W + 1)'(2));

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps the decoder select through rows 0..7, holding enable for DWELL_CYCLES per row with an
// optional BLANK_CYCLES gap between rows; one-shot or continuous, with start/stop control.
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  decoder_scan_sequencer_if.slave    bus
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = count_width(MAX_CYCLES);

  scan_state_t      state, state_nxt;
  logic [SEL_W-1:0] select_q, select_nxt;
  logic             oneshot_q, oneshot_nxt;
  logic             stop_pending, stop_pending_nxt;
  logic             stop_req;
  logic             enable_q, busy_q, row_done_q, frame_done_q;
  logic             row_done_nxt;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expire;
  logic             tmr_expire_next;

  scan_dwell_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (tmr_load),
    .value       (tmr_value),
    .expire      (tmr_expire),
    .expire_next (tmr_expire_next)
  );

  // A stop seen on the same edge as the row's end counts as already pending.
  assign stop_req = stop_pending | bus.stop;

  always_comb begin
    state_nxt   = state;
    select_nxt  = select_q;
    oneshot_nxt = oneshot_q;
    tmr_load    = 1'b0;
    tmr_value   = CNT_W'(DWELL_CYCLES);

    unique case (state)
      SCAN_IDLE: begin
        select_nxt = '0;
        if (bus.start && !bus.stop) begin
          state_nxt   = SCAN_ACTIVE;
          oneshot_nxt = bus.mode_oneshot;
          tmr_load    = 1'b1;
        end
      end

      SCAN_ACTIVE: begin
        if (tmr_expire) begin
          if (stop_req || (select_q == LAST_ROW && oneshot_q)) begin
            state_nxt  = SCAN_IDLE;
            select_nxt = '0;
          end else if (BLANK_CYCLES > 0) begin
            state_nxt = SCAN_BLANK;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(BLANK_CYCLES);
          end else begin
            select_nxt = select_q + SEL_W'(1);
            tmr_load   = 1'b1;
          end
        end
      end

      SCAN_BLANK: begin
        // Unlike ACTIVE, a gap is abandoned immediately so the next row never lights.
        if (stop_req) begin
          state_nxt  = SCAN_IDLE;
          select_nxt = '0;
        end else if (tmr_expire) begin
          state_nxt  = SCAN_ACTIVE;
          select_nxt = select_q + SEL_W'(1);
          tmr_load   = 1'b1;
        end
      end

      default: begin
        state_nxt  = SCAN_IDLE;
        select_nxt = '0;
      end
    endcase

    if (state_nxt == SCAN_IDLE) begin
      stop_pending_nxt = 1'b0;
    end else begin
      stop_pending_nxt = stop_pending | (bus.stop && state != SCAN_IDLE);
    end

    row_done_nxt = (state_nxt == SCAN_ACTIVE) && tmr_expire_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SCAN_IDLE;
      select_q     <= '0;
      oneshot_q    <= 1'b0;
      stop_pending <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      select_q     <= select_nxt;
      oneshot_q    <= oneshot_nxt;
      stop_pending <= stop_pending_nxt;
      enable_q     <= (state_nxt == SCAN_ACTIVE);
      busy_q       <= (state_nxt != SCAN_IDLE);
      row_done_q   <= row_done_nxt;
      frame_done_q <= row_done_nxt && (select_nxt == LAST_ROW);
    end
  end

  assign bus.select     = select_q;
  assign bus.enable     = enable_q;
  assign bus.busy       = busy_q;
  assign bus.row_done   = row_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: one instance with dwell 4 / blank 1 and one with
// dwell 1 / no blank, both driven through the same scenarios and checked cycle by cycle.
module tb_decoder_scan_sequencer;
  import decoder_scan_sequencer_pkg::*;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  decoder_scan_sequencer_if if_a ();
  decoder_scan_sequencer_if if_b ();

  decoder_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  decoder_scan_sequencer #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed vector: {busy, enable, select[2:0], row_done, frame_done}
  function automatic logic [6:0] obs_a();
    return {if_a.busy, if_a.enable, if_a.select, if_a.row_done, if_a.frame_done};
  endfunction

  function automatic logic [6:0] obs_b();
    return {if_b.busy, if_b.enable, if_b.select, if_b.row_done, if_b.frame_done};
  endfunction

  // First cycle that must show IDLE, given the start at cycle 0, the timing parameters,
  // an optional stop pulse at cycle s and an optional reset pulse at cycle r (-1 = none).
  function automatic int idle_from(input int d, input int b, input bit oneshot,
                                   input int s, input int r);
    int p, nat, k, off, cand;
    p   = d + b;
    nat = oneshot ? (1 + 7 * p + d) : 32'h3fff_ffff;
    if (s >= 1 && s < nat) begin
      k    = (s - 1) / p;
      off  = (s - 1) % p;
      cand = (off < d) ? (1 + k * p + d) : (s + 1);
      if (cand < nat) nat = cand;
    end
    if (r >= 1 && (r + 1) < nat) nat = r + 1;
    return nat;
  endfunction

  // Expected vector at cycle c: row k is enabled from 1 + k*(d+b) for d cycles.
  function automatic logic [6:0] exp_at(input int c, input int d, input int b, input int idle);
    int p, k, off;
    logic [2:0] row;
    logic en, rd;
    if (c < 1 || c >= idle) return 7'd0;
    p   = d + b;
    k   = (c - 1) / p;
    off = (c - 1) % p;
    row = 3'(k % NUM_ROWS);
    en  = (off < d);
    rd  = (off == d - 1);
    return {1'b1, en, row, rd, rd && (row == 3'd7)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start at cycle 0 and checks both instances for n cycles; stop_cyc / rst_cyc pulse those
  // inputs, extra_start re-pulses start on instance A with the mode flipped.
  task automatic run_scn(input string name, input bit oneshot, input int n,
                         input int stop_cyc, input int rst_cyc, input int extra_start);
    int idle_a, idle_b;
    idle_a = idle_from(4, 1, oneshot, stop_cyc, rst_cyc);
    idle_b = idle_from(1, 0, oneshot, stop_cyc, rst_cyc);
    if_a.start = 1'b1;  if_b.start = 1'b1;
    if_a.mode_oneshot = oneshot;  if_b.mode_oneshot = oneshot;
    if_a.stop = 1'b0;   if_b.stop = 1'b0;
    for (int c = 1; c <= n; c++) begin
      step();
      rst               = (c == rst_cyc);
      if_a.start        = (c == extra_start);
      if_b.start        = 1'b0;
      if_a.mode_oneshot = (c == extra_start) ? ~oneshot : oneshot;
      if_a.stop         = (c == stop_cyc);
      if_b.stop         = (c == stop_cyc);
      exp_q.push_back(exp_at(c, 4, 1, idle_a));
      check($sformatf("%s_a c%0d", name, c), 32'(obs_a()), 32'(exp_q.pop_front()));
      exp_q.push_back(exp_at(c, 1, 0, idle_b));
      check($sformatf("%s_b c%0d", name, c), 32'(obs_b()), 32'(exp_q.pop_front()));
    end
    rst = 1'b0;
    if_a.start = 1'b0;  if_b.start = 1'b0;
    if_a.stop  = 1'b0;  if_b.stop  = 1'b0;
  endtask

  task automatic start_stop_idle();
    if_a.start = 1'b1;  if_b.start = 1'b1;
    if_a.stop  = 1'b1;  if_b.stop  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if_a.start = 1'b0;  if_b.start = 1'b0;
      if_a.stop  = 1'b0;  if_b.stop  = 1'b0;
      check($sformatf("start_stop_a c%0d", c), 32'(obs_a()), 32'd0);
      check($sformatf("start_stop_b c%0d", c), 32'(obs_b()), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_a.start = 1'b0;  if_a.stop = 1'b0;  if_a.mode_oneshot = 1'b0;
    if_b.start = 1'b0;  if_b.stop = 1'b0;  if_b.mode_oneshot = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 32'(obs_a()), 32'd0);
    check("reset_b", 32'(obs_b()), 32'd0);
    check("reset_state_a", 32'(if_a.state), 32'(SCAN_IDLE));
    rst = 1'b0;
    step();

    run_scn("oneshot",    1'b1,  44,  -1, -1, 12);
    run_scn("cont",       1'b0, 124, 120, -1, -1);
    run_scn("stop_row",   1'b1,  14,   7, -1, -1);
    run_scn("stop_blank", 1'b1,  10,   5, -1, -1);
    run_scn("stop_row7",  1'b0,  44,  39, -1, -1);
    start_stop_idle();
    run_scn("reset",      1'b1,  24,  -1, 20, -1);
    run_scn("restart",    1'b1,  12,  -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
